alarm_clock_core: RTL and testbench
===================================

ALARM_CLOCK_CORE -- requirements
Module: alarm_clock_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clk_clk cycles per second (>=4).
REQ-002 SHALL have parameter N_ALARMS, default 2, number of independent alarms (1..8).
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes (1..59).
REQ-004 SHALL have parameter RING_MAX_S, default 60, seconds an unattended alarm rings.
REQ-005 SHALL run on one clock with asynchronous active-low reset: clk_clk in 1 system clock; reset_reset_n in 1 async active-low reset.
REQ-006 SHALL have ports: set_valid in 1 time-load strobe; set_h/set_m/set_s in 5/6/6 binary time to load.
REQ-007 SHALL have ports: alm_wr in 1; alm_idx in clog2(N_ALARMS) (min 1); alm_h in 5; alm_m in 6; alm_en in 1 (alarm register write).
REQ-008 SHALL have ports: mode_12h in 1 display mode; snooze in 1 pulse; dismiss in 1 pulse.
REQ-009 SHALL have ports: sevseg_hours_tens/units, sevseg_mins_tens/units, sevseg_secs_tens/units out 7 each, active-low {g,f,e,d,c,b,a}.
REQ-010 SHALL have ports: buzzer out 1; pm out 1; ringing out 1; alarm_active out N_ALARMS; sec_tick out 1; set_err out 1.

Function
REQ-011 Prescaler SHALL count 0..CLK_HZ-1; sec_tick SHALL be a one-cycle pulse on the cycle the count wraps.
REQ-012 On sec_tick, time SHALL advance: s 59->0 carries m, m 59->0 carries h, h 23->0; all binary internally.
REQ-013 set_valid with h<=23, m<=59, s<=59 SHALL load time next cycle and clear prescaler; otherwise time unchanged and set_err pulses 1 cycle.
REQ-014 set_valid SHALL win over a coincident sec_tick; loading SHALL never trigger an alarm.
REQ-015 alm_wr SHALL load alarm[alm_idx] {h,m,en} next cycle; alm_idx>=N_ALARMS or h>23 or m>59 SHALL be ignored with set_err pulse.
REQ-016 Alarm i SHALL match on the sec_tick cycle producing time alm_h:alm_m:00 with en=1; matching sets alarm_active[i].
REQ-017 FSM states IDLE, RINGING, SNOOZED; ringing=1 exactly in RINGING.
REQ-018 IDLE->RINGING on any match; ring-second counter cleared.
REQ-019 RINGING: new match ORs into alarm_active and restarts ring counter; after RING_MAX_S sec_ticks -> IDLE, alarm_active cleared.
REQ-020 RINGING + snooze -> SNOOZED, counter loaded with SNOOZE_MIN*60 seconds; alarm_active held.
REQ-021 SNOOZED: counter decrements per sec_tick; reaching 0 -> RINGING with ring counter cleared; a match -> RINGING immediately.
REQ-022 dismiss in RINGING or SNOOZED -> IDLE, alarm_active cleared; dismiss wins over simultaneous snooze or match; snooze in IDLE/SNOOZED ignored.
REQ-023 buzzer SHALL be 0 outside RINGING; in RINGING it SHALL toggle every CLK_HZ/4 cycles starting at 1 on the entry cycle.
REQ-024 Display SHALL be registered, 1-cycle latency after time change; digits decoded 0-9 standard segments.
REQ-025 mode_12h=0: hours 00-23, pm=0. mode_12h=1: h0->12, h13..23->h-12, pm=(h>=12), hours tens blanked (7'h7F) when 0.
REQ-026 Disabling an alarm (alm_wr, en=0) SHALL NOT stop a current ring.

Reset
REQ-027 reset_reset_n low SHALL asynchronously force time 00:00:00, prescaler 0, all alarms 00:00 disabled, FSM IDLE, counters 0.
REQ-028 During reset: buzzer, ringing, alarm_active, sec_tick, set_err = 0; pm=0; display shows 00:00:00 (7'h40 each) in 24h mode.
REQ-029 Reset asserted mid-ring SHALL end the ring immediately; release SHALL be used synchronously by all registers.

Verification (CLK_HZ=8, SNOOZE_MIN=1, RING_MAX_S=4)
REQ-030 Load 23:59:59, 8 cycles -> 00:00:00, sec_tick single pulse, sevseg all 7'h40.
REQ-031 Alarm0=07:30 en, load 07:29:59 -> at next sec_tick ringing=1, alarm_active=01, buzzer toggles every 2 cycles; 4 s later ringing=0.
REQ-032 Ringing, snooze -> SNOOZED, buzzer=0; 60 sec_ticks later ringing=1 again; dismiss -> IDLE, alarm_active=0.
REQ-033 snooze and dismiss same cycle while RINGING -> IDLE; set 24:00:00 -> set_err 1 cycle, time unchanged.
REQ-034 mode_12h=1, time 00:05:00 -> display 12:05:00 pm=0; 13:05:00 -> tens blank, units 1, pm=1.
REQ-035 Reset asserted while ringing -> buzzer=0, ringing=0 within same cycle, time 00:00:00 after release.

Source files
------------

// File: rtl/alarm_clock_core.sv
// Alarm clock core: prescaled time-of-day counter, N alarm slots,
// ring/snooze state machine, buzzer pattern and registered 7-segment display.

// One alarm register slot with its own match comparator.
module alarm_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [4:0] wr_h,
  input  logic [5:0] wr_m,
  input  logic       wr_en,
  input  logic       chk,
  input  logic [4:0] t_h,
  input  logic [5:0] t_m,
  input  logic [5:0] t_s,
  output logic       match
);
  logic [4:0] h;
  logic [5:0] m;
  logic       en;

  // Alarm register write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h  <= '0;
      m  <= '0;
      en <= 1'b0;
    end else if (wr) begin
      h  <= wr_h;
      m  <= wr_m;
      en <= wr_en;
    end
  end

  // chk qualifies the time being produced by a real second advance
  assign match = chk && en && (t_h == h) && (t_m == m) && (t_s == 6'd0);
endmodule

module alarm_clock_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int N_ALARMS   = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MAX_S = 60
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                set_valid,
  input  logic [4:0]          set_h,
  input  logic [5:0]          set_m,
  input  logic [5:0]          set_s,
  input  logic                alm_wr,
  input  logic [((N_ALARMS>1)?$clog2(N_ALARMS):1)-1:0] alm_idx,
  input  logic [4:0]          alm_h,
  input  logic [5:0]          alm_m,
  input  logic                alm_en,
  input  logic                mode_12h,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [6:0]          sevseg_hours_tens,
  output logic [6:0]          sevseg_hours_units,
  output logic [6:0]          sevseg_mins_tens,
  output logic [6:0]          sevseg_mins_units,
  output logic [6:0]          sevseg_secs_tens,
  output logic [6:0]          sevseg_secs_units,
  output logic                buzzer,
  output logic                pm,
  output logic                ringing,
  output logic [N_ALARMS-1:0] alarm_active,
  output logic                sec_tick,
  output logic                set_err
);
  localparam int IW  = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int PW  = $clog2(CLK_HZ);
  localparam int QTR = CLK_HZ / 4;
  localparam int QW  = $clog2(QTR + 1);
  localparam int RW  = $clog2(RING_MAX_S + 1);
  localparam int SW  = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [QW-1:0] Q_LAST    = QW'(QTR - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_MAX_S - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  logic [PW-1:0] pre;
  logic [4:0]    hh, nh, dh;
  logic [5:0]    mm, ss, nm, ns;
  logic          tick, set_ok, alm_ok, adv;
  logic [N_ALARMS-1:0] match;

  state_t              state, state_n;
  logic [N_ALARMS-1:0] active, active_n;
  logic [RW-1:0]       ring_cnt, ring_n;
  logic [SW-1:0]       snz_cnt, snz_n;
  logic                buzz;
  logic [QW-1:0]       bcnt;

  assign tick   = (pre == PRE_LAST);
  assign set_ok = set_valid && (set_h <= 5'd23) && (set_m <= 6'd59) && (set_s <= 6'd59);
  assign alm_ok = alm_wr && (32'(alm_idx) < 32'(N_ALARMS)) &&
                  (alm_h <= 5'd23) && (alm_m <= 6'd59);
  // a load on the tick cycle pre-empts the advance, so it can never match
  assign adv    = tick && !set_ok;

  // Time one second ahead, with carries
  always_comb begin
    nh = hh;
    nm = mm;
    ns = ss + 6'd1;
    if (ss == 6'd59) begin
      ns = 6'd0;
      nm = mm + 6'd1;
      if (mm == 6'd59) begin
        nm = 6'd0;
        nh = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
      end
    end
  end

  // Prescaler and time-of-day registers; a valid load restarts the second
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre <= '0;
      hh  <= '0;
      mm  <= '0;
      ss  <= '0;
    end else if (set_ok) begin
      pre <= '0;
      hh  <= set_h;
      mm  <= set_m;
      ss  <= set_s;
    end else if (tick) begin
      pre <= '0;
      hh  <= nh;
      mm  <= nm;
      ss  <= ns;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Single-cycle error flag for rejected time loads or alarm writes
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) set_err <= 1'b0;
    else                set_err <= (set_valid && !set_ok) || (alm_wr && !alm_ok);
  end

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_alm
    alarm_slot u_slot (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .wr    (alm_ok && (alm_idx == IW'(i))),
      .wr_h  (alm_h),
      .wr_m  (alm_m),
      .wr_en (alm_en),
      .chk   (adv),
      .t_h   (nh),
      .t_m   (nm),
      .t_s   (ns),
      .match (match[i])
    );
  end

  // Ring FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      active   <= '0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      state    <= state_n;
      active   <= active_n;
      ring_cnt <= ring_n;
      snz_cnt  <= snz_n;
    end
  end

  // Ring FSM next state: dismiss > new match > snooze > second timeout
  always_comb begin
    state_n  = state;
    active_n = active;
    ring_n   = ring_cnt;
    snz_n    = snz_cnt;
    unique case (state)
      IDLE: begin
        if (|match) begin
          state_n  = RINGING;
          active_n = match;
          ring_n   = '0;
        end
      end
      RINGING: begin
        if (dismiss) begin
          state_n  = IDLE;
          active_n = '0;
        end else if (|match) begin
          active_n = active | match;
          ring_n   = '0;
        end else if (snooze) begin
          state_n = SNOOZED;
          snz_n   = SNZ_LOAD;
        end else if (tick) begin
          if (ring_cnt == RING_LAST) begin
            state_n  = IDLE;
            active_n = '0;
            ring_n   = '0;
          end else begin
            ring_n = ring_cnt + 1'b1;
          end
        end
      end
      SNOOZED: begin
        if (dismiss) begin
          state_n  = IDLE;
          active_n = '0;
        end else if (|match) begin
          state_n  = RINGING;
          active_n = active | match;
          ring_n   = '0;
        end else if (tick) begin
          if (snz_cnt == SW'(1)) begin
            state_n = RINGING;
            ring_n  = '0;
            snz_n   = '0;
          end else begin
            snz_n = snz_cnt - 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Buzzer square wave, phase restarts high on every entry into RINGING
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      buzz <= 1'b0;
      bcnt <= '0;
    end else if (state_n == RINGING && state != RINGING) begin
      buzz <= 1'b1;
      bcnt <= '0;
    end else if (state_n == RINGING) begin
      if (bcnt == Q_LAST) begin
        buzz <= ~buzz;
        bcnt <= '0;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end else begin
      buzz <= 1'b0;
      bcnt <= '0;
    end
  end

  assign ringing      = (state == RINGING);
  assign buzzer       = buzz;
  assign alarm_active = active;
  assign sec_tick     = tick;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Displayed hour value for the selected mode
  always_comb begin
    dh = hh;
    if (mode_12h) begin
      if (hh == 5'd0)       dh = 5'd12;
      else if (hh > 5'd12)  dh = hh - 5'd12;
    end
  end

  // Registered display; blank leading hour digit in 12h mode
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sevseg_hours_tens  <= 7'h40;
      sevseg_hours_units <= 7'h40;
      sevseg_mins_tens   <= 7'h40;
      sevseg_mins_units  <= 7'h40;
      sevseg_secs_tens   <= 7'h40;
      sevseg_secs_units  <= 7'h40;
      pm                 <= 1'b0;
    end else begin
      sevseg_hours_tens  <= (mode_12h && dh < 5'd10) ? 7'h7F : seg7(4'(dh / 5'd10));
      sevseg_hours_units <= seg7(4'(dh % 5'd10));
      sevseg_mins_tens   <= seg7(4'(mm / 6'd10));
      sevseg_mins_units  <= seg7(4'(mm % 6'd10));
      sevseg_secs_tens   <= seg7(4'(ss / 6'd10));
      sevseg_secs_units  <= seg7(4'(ss % 6'd10));
      pm                 <= mode_12h && (hh >= 5'd12);
    end
  end
endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a seconds-of-day model.
module tb_alarm_clock_core;
  localparam int CLK_HZ = 8, NA = 2, SNZ = 1, RMAX = 4;

  logic clk = 0, rst_n = 0;
  logic set_valid = 0, alm_wr = 0, alm_en = 0, mode_12h = 0, snooze = 0, dismiss = 0;
  logic [4:0] set_h = 0, alm_h = 0;
  logic [5:0] set_m = 0, set_s = 0, alm_m = 0;
  logic [0:0] alm_idx = 0;
  logic [6:0] s_ht, s_hu, s_mt, s_mu, s_st, s_su;
  logic buzzer, pm, ringing, sec_tick, set_err;
  logic [NA-1:0] alarm_active;

  int n_cmp = 0, n_bad = 0;
  bit cmp_on = 0;

  always #5 clk = ~clk;

  alarm_clock_core #(.CLK_HZ(CLK_HZ), .N_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_MAX_S(RMAX)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .set_valid(set_valid), .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .alm_wr(alm_wr), .alm_idx(alm_idx), .alm_h(alm_h), .alm_m(alm_m), .alm_en(alm_en),
    .mode_12h(mode_12h), .snooze(snooze), .dismiss(dismiss),
    .sevseg_hours_tens(s_ht), .sevseg_hours_units(s_hu),
    .sevseg_mins_tens(s_mt), .sevseg_mins_units(s_mu),
    .sevseg_secs_tens(s_st), .sevseg_secs_units(s_su),
    .buzzer(buzzer), .pm(pm), .ringing(ringing), .alarm_active(alarm_active),
    .sec_tick(sec_tick), .set_err(set_err)
  );

  // ---------------- reference model (seconds of day) ----------------
  // m_st: 0 idle, 1 ringing, 2 snoozed
  int m_pre = 0, m_t = 0, m_st = 0, m_ring_left = 0, m_snz_left = 0, m_age = 0;
  int m_disp_t = 0, m_al_min[NA];
  bit m_disp_12 = 0, m_err = 0, m_al_en[NA];
  logic [NA-1:0] m_act = '0, mv_hit;
  int mv_nt;
  bit mv_tick, mv_sok, mv_aok, mv_was;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre = 0; m_t = 0; m_st = 0; m_ring_left = 0; m_snz_left = 0; m_age = 0;
      m_disp_t = 0; m_disp_12 = 0; m_err = 0; m_act = '0;
      for (int i = 0; i < NA; i++) begin m_al_min[i] = 0; m_al_en[i] = 0; end
    end else begin
      mv_tick = (m_pre == CLK_HZ - 1);
      mv_sok  = set_valid && set_h <= 23 && set_m <= 59 && set_s <= 59;
      mv_aok  = alm_wr && int'(alm_idx) < NA && alm_h <= 23 && alm_m <= 59;
      m_err   = (set_valid && !mv_sok) || (alm_wr && !mv_aok);
      m_disp_t = m_t; m_disp_12 = mode_12h;
      mv_nt = (m_t + 1) % 86400;
      mv_hit = '0;
      if (mv_tick && !mv_sok)
        for (int i = 0; i < NA; i++)
          if (m_al_en[i] && m_al_min[i] * 60 == mv_nt) mv_hit[i] = 1'b1;
      if (mv_sok) begin
        m_t = int'(set_h) * 3600 + int'(set_m) * 60 + int'(set_s); m_pre = 0;
      end else if (mv_tick) begin
        m_t = mv_nt; m_pre = 0;
      end else m_pre++;
      if (mv_aok) begin
        m_al_min[alm_idx] = int'(alm_h) * 60 + int'(alm_m);
        m_al_en[alm_idx]  = alm_en;
      end
      mv_was = (m_st == 1);
      case (m_st)
        0: if (|mv_hit) begin m_st = 1; m_act = mv_hit; m_ring_left = RMAX; end
        1: if (dismiss) begin m_st = 0; m_act = '0; end
           else if (|mv_hit) begin m_act |= mv_hit; m_ring_left = RMAX; end
           else if (snooze) begin m_st = 2; m_snz_left = SNZ * 60; end
           else if (mv_tick) begin
             m_ring_left--;
             if (m_ring_left == 0) begin m_st = 0; m_act = '0; end
           end
        default: if (dismiss) begin m_st = 0; m_act = '0; end
           else if (|mv_hit) begin m_st = 1; m_act |= mv_hit; m_ring_left = RMAX; end
           else if (mv_tick) begin
             m_snz_left--;
             if (m_snz_left == 0) begin m_st = 1; m_ring_left = RMAX; end
           end
      endcase
      if (m_st == 1) m_age = mv_was ? m_age + 1 : 0;
    end
  end

  function automatic logic [6:0] segd(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] exp_seg(input int t, input bit twelve);
    int h, mi, s, hd;
    logic [6:0] ht;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    hd = twelve ? ((h % 12 == 0) ? 12 : h % 12) : h;
    ht = (twelve && hd < 10) ? 7'h7F : segd(hd / 10);
    return {ht, segd(hd % 10), segd(mi / 10), segd(mi % 10), segd(s / 10), segd(s % 10)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("sec_tick", 64'(sec_tick), 64'(m_pre == CLK_HZ - 1));
      chk("set_err", 64'(set_err), 64'(m_err));
      chk("ringing", 64'(ringing), 64'(m_st == 1));
      chk("buzzer", 64'(buzzer), 64'(m_st == 1 && ((m_age / (CLK_HZ / 4)) % 2 == 0)));
      chk("alarm_active", 64'(alarm_active), 64'(m_act));
      chk("pm", 64'(pm), 64'(m_disp_12 && m_disp_t / 3600 >= 12));
      chk("sevseg", 64'({s_ht, s_hu, s_mt, s_mu, s_st, s_su}), 64'(exp_seg(m_disp_t, m_disp_12)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(); @(posedge clk); #2; endtask

  task automatic do_set(input int h, input int m, input int s);
    set_valid = 1; set_h = 5'(h); set_m = 6'(m); set_s = 6'(s);
    step(); set_valid = 0;
  endtask

  task automatic do_alm(input int idx, input int h, input int m, input bit en);
    alm_wr = 1; alm_idx = 1'(idx); alm_h = 5'(h); alm_m = 6'(m); alm_en = en;
    step(); alm_wr = 0;
  endtask

  task automatic pulse(input bit sn, input bit dm);
    snooze = sn; dismiss = dm; step(); snooze = 0; dismiss = 0;
  endtask

  task automatic wait_ring(input bit tgt, input int maxc, output int n);
    n = 0;
    while (ringing !== tgt && n < maxc) begin step(); n++; end
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    while (sec_tick !== 1'b1 && n < maxc) begin step(); n++; end
  endtask

  int n, r, b;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    cmp_on = 1;
    chk("rst_seg", 64'({s_ht, s_hu, s_mt, s_mu, s_st, s_su}), {22'd0, {6{7'h40}}});
    chk("rst_outs", 64'({buzzer, ringing, alarm_active, sec_tick, set_err, pm}), 64'd0);
    rst_n = 1;
    step();

    // Midnight rollover
    do_set(23, 59, 59);
    wait_tick(20, n);
    chk("tick_wait", 64'(n), 64'd7);
    step();
    chk("tick_single", 64'(sec_tick), 64'd0);
    step();
    chk("midnight_seg", 64'({s_ht, s_hu, s_mt, s_mu, s_st, s_su}), {22'd0, {6{7'h40}}});

    // Alarm 0 at 07:30 rings, buzzer pattern, timeout after RMAX seconds
    do_alm(0, 7, 30, 1);
    do_set(7, 29, 59);
    repeat (7) step();
    chk("pre_ring", 64'(ringing), 64'd0);
    step();
    chk("ring_on", 64'({ringing, alarm_active, buzzer}), 64'({1'b1, 2'b01, 1'b1}));
    step(); chk("buzz1", 64'(buzzer), 64'd1);
    step(); chk("buzz2", 64'(buzzer), 64'd0);
    step(); chk("buzz3", 64'(buzzer), 64'd0);
    step(); chk("buzz4", 64'(buzzer), 64'd1);
    wait_ring(0, 100, n);
    chk("ring_timeout", 64'(n), 64'd28);

    // Snooze then re-ring after 60 s, then dismiss
    do_set(7, 29, 59);
    repeat (8) step();
    chk("ring2", 64'(ringing), 64'd1);
    pulse(1, 0);
    chk("snoozed", 64'({ringing, buzzer, alarm_active}), 64'({1'b0, 1'b0, 2'b01}));
    wait_ring(1, 600, n);
    chk("snooze_len", 64'(n), 64'd479);
    pulse(0, 1);
    chk("dismissed", 64'({ringing, alarm_active}), 64'd0);

    // Snooze and dismiss together, then an invalid load
    do_set(7, 29, 59);
    repeat (8) step();
    pulse(1, 1);
    chk("sn_dm", 64'({ringing, alarm_active}), 64'd0);
    step();
    chk("sn_dm_idle", 64'(ringing), 64'd0);
    do_set(24, 0, 0);
    chk("set_err_on", 64'(set_err), 64'd1);
    step();
    chk("set_err_off", 64'(set_err), 64'd0);

    // 12-hour display
    mode_12h = 1;
    do_set(0, 5, 0);
    step();
    chk("h12_midnight", 64'({s_ht, s_hu, s_mt, s_mu, pm}), 64'({7'h79, 7'h24, 7'h40, 7'h12, 1'b0}));
    do_set(13, 5, 0);
    step();
    chk("h12_pm", 64'({s_ht, s_hu, pm}), 64'({7'h7F, 7'h79, 1'b1}));
    mode_12h = 0;

    // Reset during a ring
    do_set(7, 29, 59);
    repeat (8) step();
    chk("ring3", 64'(ringing), 64'd1);
    #1 rst_n = 0;
    #1 chk("rst_ring", 64'({buzzer, ringing, alarm_active}), 64'd0);
    step(); step();
    rst_n = 1;
    step();
    chk("post_rst_seg", 64'({s_ht, s_hu, s_mt, s_mu, s_st, s_su}), {22'd0, {6{7'h40}}});

    // Randomized traffic
    do_alm(0, 7, 30, 1);
    do_alm(1, 12, 0, 1);
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 999);
      if (r < 15) begin
        if ($urandom_range(0, 4) == 0 && m_pre != CLK_HZ - 1) begin
          set_valid = 1; set_h = 5'($urandom_range(24, 31));
          set_m = 6'($urandom_range(0, 63)); set_s = 6'($urandom_range(0, 59));
        end else begin
          b = (m_al_min[$urandom_range(0, NA - 1)] * 60 - $urandom_range(1, 6) + 86400) % 86400;
          set_valid = 1; set_h = 5'(b / 3600); set_m = 6'((b / 60) % 60); set_s = 6'(b % 60);
        end
      end else if (r < 30) begin
        alm_wr = 1; alm_idx = 1'($urandom_range(0, 1));
        alm_h = 5'($urandom_range(0, 24)); alm_m = 6'($urandom_range(0, 60));
        alm_en = ($urandom_range(0, 3) != 0);
      end
      snooze  = ($urandom_range(0, 99) < 4);
      dismiss = ($urandom_range(0, 199) < 2);
      if ($urandom_range(0, 199) == 0) mode_12h = ~mode_12h;
      step();
      set_valid = 0; alm_wr = 0; snooze = 0; dismiss = 0;
    end
    step();
    cmp_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
